// File: rtl/parking_pkg.sv
// ============================================================================
// parking_pkg : shared widths, blank code and converter state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int CNT_W = 14;
    localparam int BCD_W = 16;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dd_converter.sv
// ============================================================================
// bcd_dd_converter : sequential double-dabble, 14-bit binary to 16-bit BCD
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_dd_converter
    import parking_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] bin,
    output logic             accept,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [3:0] ITER_LAST = 4'(CNT_W - 1);

    conv_state_t      r_state;
    conv_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_cnt;
    logic [BCD_W-1:0] w_adj;

    assign w_adj = dd_adjust(r_bcd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Operand is captured on acceptance so it matches the value that raised start.
            if (accept) begin
                r_bin <= bin;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_bin[CNT_W-1]};
                r_bin <= {r_bin[CNT_W-2:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        accept      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    accept      = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD:  w_state_nxt = SHIFT;
            SHIFT: if (r_cnt == ITER_LAST) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/occupancy_bcd_driver.sv
// ============================================================================
// occupancy_bcd_driver : lot occupancy counter with blanked BCD free-space digits
// Rev 1.0
// ============================================================================
`default_nettype none

module occupancy_bcd_driver
    import parking_pkg::*;
#(
    parameter int   CAPACITY = 200,
    parameter logic LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_in,
    input  logic       car_out,
    output logic [3:0] digit_0,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic       full,
    output logic       empty,
    output logic       reject,
    output logic       underflow,
    output logic       busy,
    output logic       digits_upd
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] r_occ;
    logic             r_pending;
    logic             r_armed;
    logic             w_inc;
    logic             w_dec;
    logic             w_can_inc;
    logic             w_can_dec;
    logic             w_occ_chg;
    logic             w_accept;
    logic             w_done;
    logic [CNT_W-1:0] w_free;
    logic [BCD_W-1:0] w_bcd;
    logic [BCD_W-1:0] w_shown;
    logic             w_lead;

    assign w_inc     = car_in & ~car_out;
    assign w_dec     = car_out & ~car_in;
    assign w_can_inc = (r_occ != CAP);
    assign w_can_dec = (r_occ != '0);
    assign w_occ_chg = (w_inc & w_can_inc) | (w_dec & w_can_dec);
    assign w_free    = CAP - r_occ;
    assign full      = (r_occ == CAP);
    assign empty     = (r_occ == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ     <= '0;
            reject    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            reject    <= w_inc & ~w_can_inc;
            underflow <= w_dec & ~w_can_dec;
            if (w_inc && w_can_inc) begin
                r_occ <= r_occ + CNT_W'(1);
            end else if (w_dec && w_can_dec) begin
                r_occ <= r_occ - CNT_W'(1);
            end
        end
    end

    // A fresh change wins over the acceptance clear so the latest value is never lost.
    // The first edge after reset release only arms the converter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b1;
            r_armed   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_occ_chg) begin
                r_pending <= 1'b1;
            end else if (w_accept) begin
                r_pending <= 1'b0;
            end
        end
    end

    bcd_dd_converter u_conv (
        .clk    (clk),
        .reset  (reset),
        .start  (r_pending & r_armed),
        .bin    (w_free),
        .accept (w_accept),
        .busy   (busy),
        .done   (w_done),
        .bcd    (w_bcd)
    );

    always_comb begin
        w_shown = w_bcd;
        w_lead  = LZ_BLANK;
        for (int i = 3; i >= 1; i--) begin
            if (w_lead && (w_bcd[i*4 +: 4] == 4'd0)) begin
                w_shown[i*4 +: 4] = BLANK_DIGIT;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {digit_0, digit_1, digit_2, digit_3} <= {4{BLANK_DIGIT}};
            digits_upd                           <= 1'b0;
        end else begin
            digits_upd <= w_done;
            if (w_done) begin
                {digit_0, digit_1, digit_2, digit_3} <= w_shown;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_occupancy_bcd_driver.sv
// ============================================================================
// tb_occupancy_bcd_driver : directed self-checking bench for occupancy_bcd_driver
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_occupancy_bcd_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic car_in = 1'b0;
    logic car_out = 1'b0;
    logic car_in_b = 1'b0;
    logic idle_in = 1'b0;

    logic [3:0] d0, d1, d2, d3;
    logic full, empty, reject, underflow, busy, upd;
    logic [3:0] b0, b1, b2, b3;
    logic b_full, b_empty, b_reject, b_underflow, b_busy, b_upd;
    logic [3:0] m0, m1, m2, m3;
    logic m_full, m_empty, m_reject, m_underflow, m_busy, m_upd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    occupancy_bcd_driver #(.CAPACITY(200), .LZ_BLANK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .car_in(car_in), .car_out(car_out),
        .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3),
        .full(full), .empty(empty), .reject(reject), .underflow(underflow),
        .busy(busy), .digits_upd(upd)
    );

    occupancy_bcd_driver #(.CAPACITY(9999), .LZ_BLANK(1'b0)) u_big (
        .clk(clk), .reset(reset), .car_in(car_in_b), .car_out(idle_in),
        .digit_0(b0), .digit_1(b1), .digit_2(b2), .digit_3(b3),
        .full(b_full), .empty(b_empty), .reject(b_reject), .underflow(b_underflow),
        .busy(b_busy), .digits_upd(b_upd)
    );

    occupancy_bcd_driver #(.CAPACITY(1005), .LZ_BLANK(1'b1)) u_mid (
        .clk(clk), .reset(reset), .car_in(idle_in), .car_out(idle_in),
        .digit_0(m0), .digit_1(m1), .digit_2(m2), .digit_3(m3),
        .full(m_full), .empty(m_empty), .reject(m_reject), .underflow(m_underflow),
        .busy(m_busy), .digits_upd(m_upd)
    );

    wire [15:0] dig   = {d0, d1, d2, d3};
    wire [15:0] dig_b = {b0, b1, b2, b3};
    wire [15:0] dig_m = {m0, m1, m2, m3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic i_in, input logic i_out);
        car_in  = i_in;
        car_out = i_out;
        tick();
        car_in  = 1'b0;
        car_out = 1'b0;
    endtask

    // Runs n cycles and returns how many digits_upd pulses the main instance gave.
    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (upd) pulses++;
        end
    endtask

    initial begin
        int cnt;
        int n_upd;
        logic [15:0] first_shown;

        tick();
        tick();
        check("rst_digits", dig, 16'hFFFF);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_pulses", {reject, underflow, upd, busy}, 4'b0000);

        // First conversion: digits_upd on the 18th edge after release.
        reset = 1'b0;
        run_count(17, cnt);
        check("first_conv_early_upd", cnt, 0);
        tick();
        check("first_conv_upd", upd, 1'b1);
        check("first_conv_digits", dig, 16'hF200);
        check("first_conv_empty_full", {empty, full}, 2'b10);
        check("big_first_digits", dig_b, 16'h9999);
        check("mid_inner_zeros", dig_m, 16'h1005);
        tick();
        check("upd_one_cycle", upd, 1'b0);

        car_in_b = 1'b1;
        tick();
        car_in_b = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("big_no_blank", dig_b, 16'h9998);

        // One car in: 17-clock latency to the display.
        pulse(1'b1, 1'b0);
        check("in1_empty", empty, 1'b0);
        check("in1_reject", reject, 1'b0);
        run_count(16, cnt);
        check("in1_early_upd", cnt, 0);
        tick();
        check("in1_upd", upd, 1'b1);
        check("in1_digits", dig, 16'hF199);
        for (int k = 0; k < 3; k++) tick();

        for (int n = 1; n < 200; n++) begin
            pulse(1'b1, 1'b0);
            for (int k = 0; k < 19; k++) tick();
        end
        check("full_flag", full, 1'b1);
        check("full_digits", dig, 16'hFFF0);

        pulse(1'b1, 1'b0);
        check("full_reject", reject, 1'b1);
        check("full_hold", full, 1'b1);
        run_count(20, cnt);
        check("reject_no_upd", cnt, 0);
        check("reject_cleared", reject, 1'b0);
        check("reject_digits", dig, 16'hFFF0);

        pulse(1'b1, 1'b1);
        check("both_full_pulses", {reject, underflow}, 2'b00);
        check("both_full_hold", full, 1'b1);
        run_count(20, cnt);
        check("both_full_no_upd", cnt, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("rst2_digits", dig, 16'hF200);

        pulse(1'b0, 1'b1);
        check("empty_underflow", underflow, 1'b1);
        check("empty_hold", empty, 1'b1);
        run_count(20, cnt);
        check("underflow_no_upd", cnt, 0);
        check("underflow_digits", dig, 16'hF200);

        pulse(1'b1, 1'b1);
        check("both_empty_pulses", {reject, underflow}, 2'b00);
        check("both_empty_hold", empty, 1'b1);
        run_count(20, cnt);
        check("both_empty_no_upd", cnt, 0);

        // Burst of five arrivals on consecutive cycles.
        n_upd = 0;
        first_shown = 16'h0000;
        car_in = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        car_in = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (upd) begin
                n_upd++;
                if (n_upd == 1) first_shown = dig;
            end
        end
        check("burst_upd_le2", (n_upd >= 1 && n_upd <= 2), 1'b1);
        check("burst_first_shown", (n_upd == 1) ? dig : first_shown, (n_upd == 1) ? 16'hF195 : 16'hF199);
        check("burst_final", dig, 16'hF195);

        // Abort mid-conversion: one arrival, then reset around shift iteration 7.
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 9; k++) tick();
        check("mid_busy", busy, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("abort_digits", dig, 16'hFFFF);
        check("abort_flags", {busy, upd, empty, full}, 4'b0010);
        tick();
        reset = 1'b0;
        run_count(17, cnt);
        check("abort_rerun_early", cnt, 0);
        tick();
        check("abort_rerun_upd", upd, 1'b1);
        check("abort_rerun_digits", dig, 16'hF200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/occupancy_bcd_driver.md
# occupancy_bcd_driver

Tracks lot occupancy from entry and exit pulses and computes the number of free spaces. It converts that free-space count to four BCD digits using a sequential double-dabble engine. The digits feed the four-digit multiplexed seven-segment display driver, with leading zeros blanked. The block sits between the gate sensor/debounce stage and the display driver.

## Interface
- CAPACITY, 200: number of spaces in the lot; legal range 1..9999.
- LZ_BLANK, 1: when 1, leading zero digits are driven as 4'hF (blank code); when 0, all four digits are shown.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- car_in  in  1  single-cycle pulse, one car entering; already debounced and synchronous to clk.
- car_out  in  1  single-cycle pulse, one car leaving; same conditioning as car_in.
- digit_0  out  4  thousands digit (leftmost), BCD or 4'hF.
- digit_1  out  4  hundreds digit, BCD or 4'hF.
- digit_2  out  4  tens digit, BCD or 4'hF.
- digit_3  out  4  units digit (rightmost), always BCD after the first conversion.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- reject  out  1  one-cycle pulse; car_in was ignored because the lot was full.
- underflow  out  1  one-cycle pulse; car_out was ignored because occupancy was 0.
- busy  out  1  conversion in progress.
- digits_upd  out  1  one-cycle pulse; the digit outputs changed this cycle.

## Operation
- Occupancy register occ is 14 bits wide, range 0..CAPACITY. The free-space value is free = CAPACITY − occ, 14 bits.
- car_in alone: occ increments if occ < CAPACITY; otherwise occ holds and reject pulses.
- car_out alone: occ decrements if occ > 0; otherwise occ holds and underflow pulses.
- car_in and car_out in the same cycle: occ is unchanged, with no reject or underflow, at any occ value including 0 and CAPACITY.
- full and empty are decoded from the registered occ.
- Converter FSM has states IDLE, LOAD, SHIFT, DONE.
  - IDLE goes to LOAD when the pending flag is set.
  - LOAD copies free into the shift register, clears the 16-bit BCD accumulator and clears pending.
  - SHIFT runs exactly 14 iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then left-shifts {bcd, bin} by 1.
  - DONE latches the digits, applies blanking, pulses digits_upd, then returns to IDLE.
- pending is set on every cycle in which occ changes, and at reset release. A change during LOAD, SHIFT or DONE only sets pending, so the converter reruns with the latest value after DONE.
- Digit outputs change only in DONE, so torn or intermediate values are never visible.
- Blanking when LZ_BLANK = 1: scan from digit_0 rightward and replace each zero with 4'hF until the first nonzero digit. digit_3 is never blanked, so free = 0 displays as F,F,F,0.
- busy is high in LOAD, SHIFT and DONE.

## Timing
- Reset values:
  - occ = 0, so free = CAPACITY; full = 0 (CAPACITY ≥ 1); empty = 1.
  - reject = 0, underflow = 0, digits_upd = 0.
  - digits = 4'hF each; FSM = IDLE; pending = 1.
- Edge E0 samples car_in/car_out; occ, full, empty, reject and underflow are valid after E0.
- Conversion schedule after E0:
  - pending is set at E0.
  - LOAD is entered at E1.
  - SHIFT spans E2..E15.
  - DONE is entered at E16; digits and digits_upd are valid after E17.
- Latency from a sampled event to updated digits is 17 clocks when idle. A back-to-back rerun adds 17 clocks.
- The first conversion after reset deassertion completes 17 edges after the first post-reset edge.
- Reset asserted mid-conversion aborts immediately to the reset values; there is no partial digit update.
- Throughput: inputs are accepted every cycle; displayed digits may lag by at most two conversions.

## Structure
- Shared package parking_pkg holds:
  - CNT_W = 14, BCD_W = 16 and BLANK_DIGIT = 4'hF.
  - The converter state encoding (IDLE = 0, LOAD = 1, SHIFT = 2, DONE = 3).
- Sub-module bcd_dd_converter contains the LOAD/SHIFT/DONE engine with a start/busy/done handshake and a 14-bit binary in, 16-bit BCD out. It is reusable for other numeric displays.
- The top level keeps the occupancy counter, the pending logic and the blanking.

## Test plan
- Reset with CAPACITY = 200, no traffic → digits F,2,0,0 and one digits_upd pulse 17 edges after the first post-reset edge; empty = 1, full = 0.
- 200 car_in pulses spaced 20 cycles apart → full = 1 and digits F,F,F,0; a 201st car_in → reject pulse, occ unchanged, no digits_upd.
- At empty, car_out → underflow pulse, digits unchanged. Same cycle car_in + car_out at full and at empty → no change, no pulses.
- Burst of 5 car_in on consecutive cycles from occ = 0 → at most two digits_upd pulses; final digits F,1,9,5; no intermediate value other than 199 shown.
- CAPACITY = 9999, LZ_BLANK = 0, one car_in → digits 9,9,9,8. With LZ_BLANK = 1 and CAPACITY = 1005, occ = 0 → 1,0,0,5 with no blanking of inner zeros.
- Assert reset at SHIFT iteration 7 → outputs return to reset values asynchronously; after release the normal first conversion completes correctly.
